// File: rtl/target_lock_unit.sv
// ---------------------------------------------------------------------------
// target_lock_unit
//
// Radar acquisition front end for the weapons control unit. Watches single-
// cycle echo reports and decides when a stable target exists. A target is
// acquired after LOCK_HITS consecutive echoes fall within TOLERANCE of the
// previous accepted range. It is dropped after two consecutive misses while
// locked, after TIMEOUT cycles without an accepted echo, or when scanning is
// disabled.
//
// Ports:
//   clk             in   1  system clock, rising edge
//   rst             in   1  asynchronous reset, active low
//   scan_enable     in   1  scanning allowed; low forces IDLE
//   echo_valid      in   1  one-cycle strobe qualifying echo_distance
//   echo_distance   in   8  echo range, unsigned
//   target_locked   out  1  high only in LOCKED
//   locked_distance out  8  last accepted range in TRACK/LOCKED, else 0
//   hit_count       out  3  consecutive matching echoes, saturates at LOCK_HITS
//   TLU_state       out  2  IDLE=00 SEARCH=01 TRACK=10 LOCKED=11
//
// All outputs come straight from flops; there is no input-to-output path.
// ---------------------------------------------------------------------------
module target_lock_unit #(
    parameter int unsigned MAX_RANGE = 200,
    parameter int unsigned TOLERANCE = 4,
    parameter int unsigned LOCK_HITS = 3,
    parameter int unsigned TIMEOUT   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_enable,
    input  logic       echo_valid,
    input  logic [7:0] echo_distance,
    output logic       target_locked,
    output logic [7:0] locked_distance,
    output logic [2:0] hit_count,
    output logic [1:0] TLU_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SEARCH = 2'b01,
        ST_TRACK  = 2'b10,
        ST_LOCKED = 2'b11
    } state_e;

    state_e     state_q;
    logic       locked_q;
    logic [7:0] dist_q;
    logic [7:0] ref_q;
    logic [2:0] hit_q;
    logic [7:0] timer_q;
    logic       miss_q;

    logic       in_range_d;
    logic [8:0] diff_d;
    logic       match_d;
    logic [2:0] hit_inc_d;
    logic       lock_reached_d;
    logic       timeout_d;

    // Echo classification against the current reference. The difference is
    // taken in 9 bits as |d - ref| so it never wraps.
    always_comb begin
        in_range_d = (echo_distance != '0) && (32'(echo_distance) <= MAX_RANGE);
        if (echo_distance >= ref_q) begin
            diff_d = {1'b0, echo_distance} - {1'b0, ref_q};
        end else begin
            diff_d = {1'b0, ref_q} - {1'b0, echo_distance};
        end
        match_d        = in_range_d && (32'(diff_d) <= TOLERANCE);
        hit_inc_d      = hit_q + 3'd1;
        lock_reached_d = (32'(hit_inc_d) == LOCK_HITS);
        // Timer holds the number of idle edges already seen; the edge on which
        // it equals TIMEOUT-1 is the TIMEOUT-th edge after the last accept.
        timeout_d      = (32'(timer_q) == (TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            locked_q <= 1'b0;
            dist_q   <= '0;
            ref_q    <= '0;
            hit_q    <= '0;
            timer_q  <= '0;
            miss_q   <= 1'b0;
        end else if (!scan_enable) begin
            // Scan disable overrides every other event, including echoes.
            state_q  <= ST_IDLE;
            locked_q <= 1'b0;
            dist_q   <= '0;
            ref_q    <= '0;
            hit_q    <= '0;
            timer_q  <= '0;
            miss_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Echoes seen here are discarded.
                    state_q <= ST_SEARCH;
                end

                ST_SEARCH: begin
                    if (echo_valid && in_range_d) begin
                        state_q <= ST_TRACK;
                        ref_q   <= echo_distance;
                        dist_q  <= echo_distance;
                        hit_q   <= 3'd1;
                        timer_q <= '0;
                    end
                end

                ST_TRACK: begin
                    if (echo_valid && match_d) begin
                        ref_q   <= echo_distance;
                        dist_q  <= echo_distance;
                        hit_q   <= hit_inc_d;
                        timer_q <= '0;
                        if (lock_reached_d) begin
                            state_q  <= ST_LOCKED;
                            locked_q <= 1'b1;
                            miss_q   <= 1'b0;
                        end
                    end else if (echo_valid && in_range_d) begin
                        // New candidate replaces the old one as hit 1.
                        ref_q   <= echo_distance;
                        dist_q  <= echo_distance;
                        hit_q   <= 3'd1;
                        timer_q <= '0;
                    end else if (echo_valid || timeout_d) begin
                        // Out-of-range echo or silence for TIMEOUT edges.
                        state_q  <= ST_SEARCH;
                        locked_q <= 1'b0;
                        dist_q   <= '0;
                        hit_q    <= '0;
                        timer_q  <= '0;
                        miss_q   <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end

                ST_LOCKED: begin
                    if (echo_valid && match_d) begin
                        ref_q   <= echo_distance;
                        dist_q  <= echo_distance;
                        timer_q <= '0;
                        miss_q  <= 1'b0;
                    end else if ((echo_valid && miss_q) || timeout_d) begin
                        state_q  <= ST_SEARCH;
                        locked_q <= 1'b0;
                        dist_q   <= '0;
                        hit_q    <= '0;
                        timer_q  <= '0;
                        miss_q   <= 1'b0;
                    end else begin
                        // A first miss does not reset the timer.
                        if (echo_valid) begin
                            miss_q <= 1'b1;
                        end
                        timer_q <= timer_q + 8'd1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign target_locked   = locked_q;
    assign locked_distance = dist_q;
    assign hit_count       = hit_q;
    assign TLU_state       = state_q;

endmodule

// File: tb/tb_target_lock_unit.sv
// ---------------------------------------------------------------------------
// tb_target_lock_unit
//
// Directed bench for target_lock_unit with default parameters
// (MAX_RANGE=200, TOLERANCE=4, LOCK_HITS=3, TIMEOUT=20). Inputs change 1 ns
// after a rising edge and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_target_lock_unit;

    logic       clk;
    logic       rst;
    logic       scan_enable;
    logic       echo_valid;
    logic [7:0] echo_distance;
    logic       target_locked;
    logic [7:0] locked_distance;
    logic [2:0] hit_count;
    logic [1:0] TLU_state;

    int unsigned n_checks;
    int unsigned n_pass;

    target_lock_unit #(
        .MAX_RANGE (200),
        .TOLERANCE (4),
        .LOCK_HITS (3),
        .TIMEOUT   (20)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .scan_enable     (scan_enable),
        .echo_valid      (echo_valid),
        .echo_distance   (echo_distance),
        .target_locked   (target_locked),
        .locked_distance (locked_distance),
        .hit_count       (hit_count),
        .TLU_state       (TLU_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] st, input logic lk,
                             input logic [7:0] ld, input logic [2:0] hc);
        check({tag, ".state"},  32'(TLU_state),       32'(st));
        check({tag, ".locked"}, 32'(target_locked),   32'(lk));
        check({tag, ".dist"},   32'(locked_distance), 32'(ld));
        check({tag, ".hits"},   32'(hit_count),       32'(hc));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_edges(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            tick();
        end
    endtask

    task automatic echo(input logic [7:0] d);
        echo_valid    = 1'b1;
        echo_distance = d;
        tick();
        echo_valid    = 1'b0;
        echo_distance = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b0;
        scan_enable   = 1'b1;
        echo_valid    = 1'b1;
        echo_distance = 8'd100;

        // Reset held for 3 edges with echoes applied
        wait_edges(3);
        check_out("reset", 2'b00, 1'b0, 8'd0, 3'd0);
        rst        = 1'b1;
        echo_valid = 1'b0;
        tick();
        check_out("rst_release", 2'b01, 1'b0, 8'd0, 3'd0);

        // Acquisition: 100, 102, 99 spaced 4 cycles
        echo(8'd100);
        check_out("acq1", 2'b10, 1'b0, 8'd100, 3'd1);
        wait_edges(3);
        echo(8'd102);
        check_out("acq2", 2'b10, 1'b0, 8'd102, 3'd2);
        wait_edges(3);
        echo(8'd99);
        check_out("acq3", 2'b11, 1'b1, 8'd99, 3'd3);

        // Miss handling while locked at 99
        echo(8'd150);
        check_out("miss1", 2'b11, 1'b1, 8'd99, 3'd3);
        echo(8'd98);
        check_out("rematch", 2'b11, 1'b1, 8'd98, 3'd3);
        echo(8'd150);
        check_out("miss_a", 2'b11, 1'b1, 8'd98, 3'd3);
        echo(8'd160);
        check_out("miss_b", 2'b01, 1'b0, 8'd0, 3'd0);

        // Candidate restart
        echo(8'd100);
        check_out("cand1", 2'b10, 1'b0, 8'd100, 3'd1);
        echo(8'd120);
        check_out("cand_restart", 2'b10, 1'b0, 8'd120, 3'd1);
        echo(8'd0);
        check_out("cand_oor", 2'b01, 1'b0, 8'd0, 3'd0);

        // Timeout from LOCKED: drop exactly 20 edges after the last accept
        echo(8'd50);
        echo(8'd52);
        echo(8'd54);
        check_out("to_lock", 2'b11, 1'b1, 8'd54, 3'd3);
        wait_edges(19);
        check_out("to_edge19", 2'b11, 1'b1, 8'd54, 3'd3);
        tick();
        check_out("to_edge20", 2'b01, 1'b0, 8'd0, 3'd0);

        // Echo on edge 19 extends the lock
        echo(8'd60);
        echo(8'd60);
        echo(8'd60);
        check_out("ext_lock", 2'b11, 1'b1, 8'd60, 3'd3);
        wait_edges(18);
        echo(8'd61);
        check_out("ext_echo19", 2'b11, 1'b1, 8'd61, 3'd3);
        wait_edges(19);
        check_out("ext_hold", 2'b11, 1'b1, 8'd61, 3'd3);
        tick();
        check_out("ext_drop", 2'b01, 1'b0, 8'd0, 3'd0);

        // Range boundaries in SEARCH, then TRACK timeout
        echo(8'd201);
        check_out("oor_201", 2'b01, 1'b0, 8'd0, 3'd0);
        echo(8'd200);
        check_out("max_200", 2'b10, 1'b0, 8'd200, 3'd1);
        wait_edges(19);
        check_out("trk_edge19", 2'b10, 1'b0, 8'd200, 3'd1);
        tick();
        check_out("trk_timeout", 2'b01, 1'b0, 8'd0, 3'd0);

        // Out-of-range echo in TRACK
        echo(8'd100);
        echo(8'd201);
        check_out("trk_oor", 2'b01, 1'b0, 8'd0, 3'd0);

        // Tolerance boundary: diff 4 matches, diff 5 restarts
        echo(8'd100);
        echo(8'd104);
        check_out("tol_4", 2'b10, 1'b0, 8'd104, 3'd2);
        echo(8'd109);
        check_out("tol_5", 2'b10, 1'b0, 8'd109, 3'd1);
        echo(8'd110);
        echo(8'd111);
        check_out("relock", 2'b11, 1'b1, 8'd111, 3'd3);

        // scan_enable drop beats a matching echo
        scan_enable   = 1'b0;
        echo_valid    = 1'b1;
        echo_distance = 8'd111;
        tick();
        check_out("scan_off", 2'b00, 1'b0, 8'd0, 3'd0);
        tick();
        check_out("scan_off_echo", 2'b00, 1'b0, 8'd0, 3'd0);
        scan_enable = 1'b1;
        tick();
        check_out("idle_echo", 2'b01, 1'b0, 8'd0, 3'd0);
        echo_valid    = 1'b0;
        echo_distance = '0;

        // Asynchronous reset mid-TRACK
        echo(8'd100);
        check_out("pre_rst", 2'b10, 1'b0, 8'd100, 3'd1);
        #2;
        rst = 1'b0;
        #1;
        check_out("async_rst", 2'b00, 1'b0, 8'd0, 3'd0);
        tick();
        rst = 1'b1;
        tick();
        check_out("post_rst", 2'b01, 1'b0, 8'd0, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/target_lock_unit.md
# target_lock_unit

Upstream acquisition stage for the weapons control unit. Consumes single-cycle radar echo reports (valid strobe plus 8-bit range) and decides when a stable target exists. Drives the `target_locked` level that the weapons control unit samples, plus the tracked range and a 2-bit state code for waveform inspection. All outputs are registered.

## Interface
- `MAX_RANGE`, 200: largest accepted echo distance; valid range is 1..MAX_RANGE.
- `TOLERANCE`, 4: maximum |new − reference| distance for an echo to count as the same target.
- `LOCK_HITS`, 3: consecutive matching echoes required to lock (2..7).
- `TIMEOUT`, 20: cycles without an accepted echo before the target is dropped (1..255).

Ports:
- `clk` input 1: single system clock, rising edge.
- `rst` input 1: one clock; reset is asynchronous and active-low.
- `scan_enable` input 1: radar scanning allowed; 0 forces IDLE.
- `echo_valid` input 1: one-cycle strobe; `echo_distance` is valid this cycle.
- `echo_distance` input 8: echo range, unsigned.
- `target_locked` output 1: high only in LOCKED.
- `locked_distance` output 8: last accepted range in TRACK or LOCKED; 0 otherwise.
- `hit_count` output 3: consecutive matching echoes; saturates at LOCK_HITS.
- `TLU_state` output 2: IDLE=00, SEARCH=01, TRACK=10, LOCKED=11.

## Operation
- Reset (`rst`=0, any time, asynchronous): state IDLE, all outputs 0, internal reference distance, miss counter and timer cleared.
- "In range" means 1 ≤ d ≤ MAX_RANGE. "Match" means in range and |d − ref| ≤ TOLERANCE. Use 9-bit unsigned difference, absolute value, no wrap.
- Priority: `scan_enable`=0 beats all other events. Any state goes to IDLE at the next edge and all outputs clear.
- IDLE: when `scan_enable`=1, go to SEARCH.
- SEARCH: ignore out-of-range echoes. On an in-range echo: ref=d, `locked_distance`=d, `hit_count`=1, timer=0, go to TRACK.
- TRACK:
  - Timer increments every cycle with no accepted echo.
  - On a match: ref=d, `locked_distance`=d, `hit_count`+1, timer=0. If the new count equals LOCK_HITS, go to LOCKED.
  - On an in-range mismatch: restart with the new candidate. ref=d, `hit_count`=1, timer=0, stay in TRACK.
  - On an out-of-range echo: go to SEARCH with `hit_count`=0.
  - When timer reaches TIMEOUT: go to SEARCH.
- LOCKED:
  - `target_locked`=1 and `hit_count` holds at LOCK_HITS.
  - On a match: update ref and `locked_distance`, timer=0, miss counter=0.
  - On a mismatch or out-of-range echo: miss counter+1 and timer continues. A second consecutive miss goes to SEARCH.
  - When timer reaches TIMEOUT: go to SEARCH.
- Leaving TRACK or LOCKED to SEARCH or IDLE clears `target_locked`, `locked_distance`, `hit_count`, and the miss counter.
- SEARCH→TRACK on the same edge counts the triggering echo as hit 1.

## Timing
- All state and output updates happen on the rising `clk` edge. Outputs show the new state immediately after the edge that sampled the event. There is no combinational input-to-output path.
- Lock latency: `target_locked` rises right after the edge that samples the LOCK_HITS-th matching echo.
- Drop latency:
  - After the edge sampling the second consecutive miss.
  - Or TIMEOUT edges after the last accepted echo; the timer compares against TIMEOUT−1 before incrementing.
  - Or one edge after `scan_enable` falls.
- An `echo_valid` held high for k cycles counts as k echoes.
- Echoes arriving in IDLE, or in the same cycle `scan_enable`=0, are discarded.
- Release of `rst` is asynchronous. The first state change happens on the first edge with `rst`=1.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with echoes applied → all outputs 0 and `TLU_state`=00. After release with `scan_enable`=1, `TLU_state`=01 after one edge.
- Acquisition: echoes 100, 102, 99 spaced 4 cycles apart → TRACK after the first with `hit_count`=1, 2 after the second, then `target_locked`=1, `TLU_state`=11, `locked_distance`=99 after the third edge.
- Candidate restart: in TRACK with ref 100, send echo 120 → `hit_count`=1, `locked_distance`=120, still 10. Send echo 0 → SEARCH, outputs cleared.
- Miss handling: while locked at 99, send echo 150 → still LOCKED, `locked_distance`=99. Send 98 → miss count cleared. Send 150 then 160 → `target_locked`=0 and `TLU_state`=01 after the second.
- Timeout: lock, then send no echoes → `target_locked` falls exactly 20 edges after the last accepted echo. An echo at edge 19 extends the lock.
- Boundaries and priority: echo 200 accepted and echo 201 ignored in SEARCH. Dropping `scan_enable` in LOCKED, in the same cycle as a matching echo, gives IDLE with all outputs 0 on the next edge. Asserting `rst` mid-TRACK clears everything immediately without waiting for a clock edge.
